mesh_packet_serializer: RTL and testbench
=========================================

// Module: mesh_packet_serializer
// PURPOSE
// - Transmit side of the mesh nibble link: accepts 32-bit spike packets from the neuron core and emits them on the router clock.
// - Each packet leaves as contiguous 4-bit nibbles on packet_out, qualified by write_enable.
// - Feeds the mesh_controller receive port: same nibble width, same write_enable strobe, and honours that port's receive_full.
// - Up to FIFO_DEPTH packets are buffered so that the core never stalls while the link is busy.
// PARAMETERS
// - PKT_W      32  spike packet width; must be a multiple of NIB_W.
// - NIB_W       4  link nibble width.
// - FIFO_DEPTH  4  packets buffered; power of two, >= 2.
// PORTS
// - rt_clk        in   1         router clock; all logic is on the rising edge.
// - rst_n         in   1         asynchronous, active-low reset.
// - spike_packet  in   PKT_W     packet from the core.
// - pkt_valid     in   1         spike_packet is valid.
// - pkt_ready     out  1         FIFO can accept; the packet is pushed on the edge where pkt_valid & pkt_ready.
// - receive_full  in   1         downstream cannot start a new packet.
// - packet_out    out  NIB_W     nibble on the link.
// - write_enable  out  1         packet_out is valid this cycle.
// - tx_busy       out  1         FSM is in SEND.
// - fifo_count    out  clog2(FIFO_DEPTH)+1   packets currently buffered.
// BEHAVIOUR
// - Reset values: pkt_ready=1, packet_out=0, write_enable=0, tx_busy=0, fifo_count=0. FIFO pointers, shift register and nibble counter are cleared.
// - Reset mid-packet: the partial packet and all buffered packets are dropped; write_enable is 0 from the reset assertion onward.
// - pkt_ready = (fifo_count != FIFO_DEPTH), registered count, so no push is possible when the FIFO is full.
// - A push and a pop on the same edge leave fifo_count unchanged.
// - FSM states: IDLE, SEND.
// - IDLE -> SEND on an edge where the FIFO is non-empty and receive_full=0:
//   - pop the head into the shift register;
//   - drive packet_out = bits[NIB_W-1:0];
//   - write_enable=1; nib_cnt=0.
// - SEND: each edge shifts right by NIB_W and increments nib_cnt. Nibbles go out LS-first, one per cycle, with no gaps inside a packet.
// - receive_full is sampled only at packet boundaries. Asserting it mid-packet never truncates or pauses the current packet.
// - On the edge that retires the last nibble (nib_cnt = PKT_W/NIB_W-1):
//   - if the FIFO is non-empty and receive_full=0, load the next packet back-to-back with no idle cycle;
//   - otherwise go to IDLE, with write_enable=0 and packet_out held at its last value.
// - Latency: a packet pushed at edge k into an empty FIFO with the FSM in IDLE gives nibble 0 with write_enable=1 after edge k+1. Nibble 7 appears after edge k+8.
// - fifo_count never wraps; the pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
// - Macro MESH_TX_PARITY_EN.
// - Defined: each packet gets one extra nibble after its data nibbles, equal to the XOR of all data nibbles, so a 32-bit packet occupies 9 write_enable cycles. nib_cnt terminal value becomes PKT_W/NIB_W.
// - Undefined: no parity nibble; 8 cycles per packet; no parity logic is present.
// STRUCTURE
// - mesh_pkg holds:
//   - PKT_W, NIB_W, NIBBLES = PKT_W/NIB_W;
//   - the tx_state_t enum {IDLE, SEND};
//   - a nibble-parity function.
//   It is shared with mesh_controller.
// - Sub-module mesh_sync_fifo (parameterised width and depth; push/pop, full/empty/count) holds the packet buffer.
// - The FSM, shift register and nib_cnt stay in this module.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles -> pkt_ready=1, write_enable=0, fifo_count=0, packet_out=0.
// - Single packet: push 0x87654321 at edge k -> write_enable=1 after edges k+1..k+8, packet_out=1,2,3,4,5,6,7,8, then write_enable=0 and tx_busy=0.
// - Back-to-back: push 0xFEDCBA98 then 0x76543210 on consecutive edges -> 16 contiguous nibbles 8,9,A..F,0..7 with no gap in write_enable.
// - Backpressure: with receive_full=1, push 5 packets -> 4 accepted, pkt_ready=0, write_enable stays 0. Release receive_full -> 32 contiguous nibbles and fifo_count falls to 0.
// - Mid-packet receive_full: assert it on nibble 3 of 0x87654321 with a second packet queued -> nibbles 4..8 still sent, the second packet is held until receive_full=0.
// - Reset mid-packet after nibble 3 -> write_enable=0 immediately, fifo_count=0. The next push restarts cleanly at nibble 0.
// - MESH_TX_PARITY_EN: 0x87654321 -> nibbles 1..8 followed by a parity nibble 0x8, 9 write_enable cycles in total.

Source files
------------

// File: rtl/mesh_pkg.sv
// mesh_pkg
// Shared definitions for the mesh nibble link, used by both the transmit
// side (mesh_packet_serializer) and the receive side (mesh_controller).
//   PKT_W      spike packet width in bits (multiple of NIB_W)
//   NIB_W      link nibble width in bits
//   NIBBLES    data nibbles per packet
//   tx_state_t transmit FSM states
//   nibble_parity  XOR of all data nibbles of a packet
package mesh_pkg;

  localparam int PKT_W   = 32;
  localparam int NIB_W   = 4;
  localparam int NIBBLES = PKT_W / NIB_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Bitwise XOR of every NIB_W-wide slice of a packet.
  function automatic logic [NIB_W-1:0] nibble_parity(input logic [PKT_W-1:0] data);
    logic [NIB_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      acc ^= data[i*NIB_W +: NIB_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/mesh_sync_fifo.sv
// mesh_sync_fifo
// Single-clock FIFO with a combinational head read (first-word fall-through),
// so the consumer can act on the head in the same cycle it sees !empty.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (pointers and count only)
//   push       write push_data (ignored when full)
//   push_data  WIDTH-bit entry to store
//   pop        retire the head entry (ignored when empty)
//   pop_data   current head entry
//   full       count == DEPTH
//   empty      count == 0
//   count      entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module mesh_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves the count unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mesh_packet_serializer.sv
// mesh_packet_serializer
// Transmit side of the mesh nibble link. Buffers spike packets from the
// neuron core and sends each one as contiguous NIB_W-bit nibbles, LS first,
// qualified by write_enable.
//   rt_clk        router clock, rising edge
//   rst_n         asynchronous active-low reset
//   spike_packet  packet from the core
//   pkt_valid     spike_packet is valid
//   pkt_ready     buffer can accept (push on pkt_valid & pkt_ready)
//   receive_full  downstream cannot start a new packet (sampled only at
//                 packet boundaries)
//   packet_out    nibble on the link
//   write_enable  packet_out valid this cycle
//   tx_busy       FSM is in SEND
//   fifo_count    packets currently buffered
// Build option: define MESH_TX_PARITY_EN to append one parity nibble (XOR of
// all data nibbles) after each packet.
module mesh_packet_serializer
  import mesh_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          rt_clk,
  input  logic                          rst_n,
  input  logic [PKT_W-1:0]              spike_packet,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic                          receive_full,
  output logic [NIB_W-1:0]              packet_out,
  output logic                          write_enable,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef MESH_TX_PARITY_EN
  localparam int FRAME_NIBS = NIBBLES + 1;
`else
  localparam int FRAME_NIBS = NIBBLES;
`endif
  localparam int SH_W  = FRAME_NIBS * NIB_W;
  localparam int CNT_W = $clog2(FRAME_NIBS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_NIBS - 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0] fifo_head;
  logic [SH_W-1:0]  frame;
  logic             load_ok;

  tx_state_t        state_q, state_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
  logic [NIB_W-1:0] packet_out_q, packet_out_d;
  logic             write_enable_q, write_enable_d;

  assign pkt_ready = !fifo_full;
  assign fifo_push = pkt_valid && pkt_ready;

  mesh_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (rt_clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (spike_packet),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The frame is the full nibble sequence for one packet; the parity nibble,
  // when present, simply rides above the data so the shifter needs no
  // special case for it.
`ifdef MESH_TX_PARITY_EN
  assign frame = {nibble_parity(fifo_head), fifo_head};
`else
  assign frame = fifo_head;
`endif

  // A new packet may only start at a boundary, with data waiting and the
  // receiver willing to take it.
  assign load_ok = !fifo_empty && !receive_full;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    nib_cnt_d      = nib_cnt_q;
    packet_out_d   = packet_out_q;
    write_enable_d = write_enable_q;
    fifo_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_ok) begin
          fifo_pop       = 1'b1;
          state_d        = SEND;
          packet_out_d   = frame[NIB_W-1:0];
          shift_d        = frame >> NIB_W;
          nib_cnt_d      = '0;
          write_enable_d = 1'b1;
        end
      end
      SEND: begin
        if (nib_cnt_q == LAST_CNT) begin
          // Last nibble retires this edge: chain straight into the next
          // packet, or drop to IDLE holding packet_out.
          if (load_ok) begin
            fifo_pop       = 1'b1;
            packet_out_d   = frame[NIB_W-1:0];
            shift_d        = frame >> NIB_W;
            nib_cnt_d      = '0;
            write_enable_d = 1'b1;
          end else begin
            state_d        = IDLE;
            write_enable_d = 1'b0;
          end
        end else begin
          packet_out_d = shift_q[NIB_W-1:0];
          shift_d      = shift_q >> NIB_W;
          nib_cnt_d    = nib_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d        = IDLE;
        write_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      nib_cnt_q      <= '0;
      packet_out_q   <= '0;
      write_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      nib_cnt_q      <= nib_cnt_d;
      packet_out_q   <= packet_out_d;
      write_enable_q <= write_enable_d;
    end
  end

  assign packet_out   = packet_out_q;
  assign write_enable = write_enable_q;
  assign tx_busy      = (state_q == SEND);

endmodule

// File: tb/tb_mesh_packet_serializer.sv
// Bench for mesh_packet_serializer. A cycle-level link model (packet counts
// and nibbles-shown per packet) predicts write_enable/tx_busy/fifo_count/
// pkt_ready; accepted packets are expanded into an expected-nibble queue that
// the monitor pops whenever the DUT drives write_enable.
module tb_mesh_packet_serializer;
  import mesh_pkg::*;

  localparam int DEPTH = 4;
`ifdef MESH_TX_PARITY_EN
  localparam int FRAME = NIBBLES + 1;
`else
  localparam int FRAME = NIBBLES;
`endif

  logic                      rt_clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [PKT_W-1:0]          spike_packet = '0;
  logic                      pkt_valid = 1'b0;
  logic                      receive_full = 1'b0;
  logic                      pkt_ready;
  logic [NIB_W-1:0]          packet_out;
  logic                      write_enable;
  logic                      tx_busy;
  logic [$clog2(DEPTH):0]    fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Link model state
  int               m_count  = 0;
  int               m_shown  = 0;
  bit               m_active = 1'b0;
  logic [NIB_W-1:0] exp_nib_q[$];
  logic [NIB_W-1:0] last_nib = '0;

  mesh_packet_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .rt_clk       (rt_clk),
    .rst_n        (rst_n),
    .spike_packet (spike_packet),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .receive_full (receive_full),
    .packet_out   (packet_out),
    .write_enable (write_enable),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  always #5 rt_clk = ~rt_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, let one rising edge pass, settle.
  task automatic cycle(input bit v, input logic [PKT_W-1:0] d, input bit rf);
    pkt_valid    = v;
    spike_packet = d;
    receive_full = rf;
    @(posedge rt_clk);
    #1;
  endtask

  // Reference model, evaluated on pre-edge inputs at every rising edge.
  initial begin
    bit               take;
    logic [NIB_W-1:0] par;
    forever begin
      @(posedge rt_clk or negedge rst_n);
      if (!rst_n) begin
        m_count  = 0;
        m_shown  = 0;
        m_active = 1'b0;
        exp_nib_q.delete();
      end else begin
        take = pkt_valid && (m_count != DEPTH);
        if (m_active && m_shown < FRAME) begin
          m_shown++;
        end else if (m_count > 0 && !receive_full) begin
          m_count--;
          m_shown  = 1;
          m_active = 1'b1;
        end else begin
          m_active = 1'b0;
        end
        if (take) begin
          m_count++;
          par = '0;
          for (int i = 0; i < NIBBLES; i++) begin
            exp_nib_q.push_back(spike_packet[i*NIB_W +: NIB_W]);
            par = par ^ spike_packet[i*NIB_W +: NIB_W];
          end
`ifdef MESH_TX_PARITY_EN
          exp_nib_q.push_back(par);
`endif
        end
      end
    end
  end

  // Monitor: compares on the falling edge, pops a nibble whenever the DUT
  // presents one.
  initial begin
    logic [NIB_W-1:0] e;
    forever begin
      @(negedge rt_clk);
      if (!rst_n) begin
        check("rst_we",      64'(write_enable), 64'(0));
        check("rst_busy",    64'(tx_busy),      64'(0));
        check("rst_count",   64'(fifo_count),   64'(0));
        check("rst_ready",   64'(pkt_ready),    64'(1));
        check("rst_pkt_out", 64'(packet_out),   64'(0));
        last_nib = '0;
      end else begin
        check("we",    64'(write_enable), 64'(m_active));
        check("busy",  64'(tx_busy),      64'(m_active));
        check("count", 64'(fifo_count),   64'(m_count));
        check("ready", 64'(pkt_ready),    64'(m_count != DEPTH));
        if (write_enable) begin
          if (exp_nib_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL nibble_unexpected: got %0h expected no nibble at %0t", packet_out, $time);
            last_nib = packet_out;
          end else begin
            e = exp_nib_q.pop_front();
            check("nibble", 64'(packet_out), 64'(e));
            last_nib = e;
          end
        end else begin
          check("hold", 64'(packet_out), 64'(last_nib));
        end
      end
    end
  end

  initial begin
    logic [PKT_W-1:0] bp_data [5];
    bp_data[0] = 32'h0000_0001;
    bp_data[1] = 32'h1234_5678;
    bp_data[2] = 32'h9ABC_DEF0;
    bp_data[3] = 32'hA5A5_5A5A;
    bp_data[4] = 32'hFFFF_0000;

    // Reset held for two cycles
    repeat (2) @(posedge rt_clk);
    #1;
    check("reset_ready", 64'(pkt_ready),    64'(1));
    check("reset_we",    64'(write_enable), 64'(0));
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);

    // Single packet
    cycle(1'b1, 32'h8765_4321, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("single_first_nibble", 64'(packet_out), 64'(4'h1));
    repeat (12) cycle(1'b0, '0, 1'b0);
    check("single_done_busy", 64'(tx_busy), 64'(0));

    // Back-to-back packets
    cycle(1'b1, 32'hFEDC_BA98, 1'b0);
    cycle(1'b1, 32'h7654_3210, 1'b0);
    repeat (22) cycle(1'b0, '0, 1'b0);

    // Backpressure: five offers while the receiver is full
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, bp_data[i], 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    check("bp_ready",  64'(pkt_ready),    64'(0));
    check("bp_we",     64'(write_enable), 64'(0));
    check("bp_count",  64'(fifo_count),   64'(DEPTH));
    repeat (45) cycle(1'b0, '0, 1'b0);
    check("bp_drained", 64'(fifo_count), 64'(0));

    // receive_full raised mid-packet with a second packet queued
    cycle(1'b1, 32'h8765_4321, 1'b0);
    cycle(1'b1, 32'h1122_3344, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    check("mid_nibble3", 64'(packet_out), 64'(4'h4));
    repeat (10) cycle(1'b0, '0, 1'b1);
    check("mid_held_we",    64'(write_enable), 64'(0));
    check("mid_held_count", 64'(fifo_count),   64'(1));
    repeat (14) cycle(1'b0, '0, 1'b0);

    // Reset in the middle of a packet
    cycle(1'b1, 32'h8765_4321, 1'b0);
    cycle(1'b1, 32'hCAFE_F00D, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_we",      64'(write_enable), 64'(0));
    check("midrst_count",   64'(fifo_count),   64'(0));
    check("midrst_pkt_out", 64'(packet_out),   64'(0));
    repeat (2) @(posedge rt_clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 32'h0BAD_BEEF, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("restart_nibble0", 64'(packet_out), 64'(4'hF));
    repeat (12) cycle(1'b0, '0, 1'b0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 3) == 0));
    end
    repeat (60) cycle(1'b0, '0, 1'b0);
    check("final_count",   64'(fifo_count),       64'(0));
    check("final_pending", 64'(exp_nib_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
